// File: rtl/cmp_sort4_ctrl.sv
// rtl/cmp_sort4_ctrl.sv - four-word sorter built around one time-shared 4-bit magnitude comparator

// 4-bit Eq/Gt/Lt magnitude comparator
module cmp4_mag (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       eq,
   output logic       gt,
   output logic       lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// Load four words, bubble-sort them in six compare-and-swap steps, then drain them
module cmp_sort4_ctrl #(
   parameter bit DESCEND = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [3:0] out_data,
   input  logic       out_ready,
   output logic       out_last,
   output logic [2:0] swaps,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SORT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] r [4];
   logic [1:0] k;
   logic [2:0] s;
   logic [1:0] pi;
   logic [1:0] pj;
   logic       cmp_eq;
   logic       cmp_gt;
   logic       cmp_lt;
   logic       do_swap;

   // Bubble schedule: pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) for steps 0..5
   always_comb begin
      pi = 2'd0;
      case (s)
         3'd0, 3'd3, 3'd5: pi = 2'd0;
         3'd1, 3'd4:       pi = 2'd1;
         3'd2:             pi = 2'd2;
         default:          pi = 2'd0;
      endcase
   end

   assign pj = pi + 2'd1;

   cmp4_mag u_cmp (
      .a  (r[pi]),
      .b  (r[pj]),
      .eq (cmp_eq),
      .gt (cmp_gt),
      .lt (cmp_lt)
   );

   // Equal words never swap, which keeps the sort stable
   assign do_swap  = ~cmp_eq & (DESCEND ? cmp_lt : cmp_gt);

   assign out_data = r[k];

   // Controller: state, word registers, counters and registered handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_LOAD;
         for (int i = 0; i < 4; i++) begin
            r[i] <= 4'd0;
         end
         k         <= 2'd0;
         s         <= 3'd0;
         swaps     <= 3'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid && in_ready) begin
                  r[k] <= in_data;
                  k    <= k + 2'd1;
                  if (k == 2'd3) begin
                     s        <= 3'd0;
                     swaps    <= 3'd0;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     state    <= ST_SORT;
                  end
               end
            end
            ST_SORT: begin
               if (do_swap) begin
                  r[pi] <= r[pj];
                  r[pj] <= r[pi];
                  swaps <= swaps + 3'd1;
               end
               if (s == 3'd5) begin
                  s         <= 3'd0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  state     <= ST_DRAIN;
               end else begin
                  s <= s + 3'd1;
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready) begin
                  k        <= k + 2'd1;
                  out_last <= (k == 2'd2);
                  if (k == 2'd3) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     state     <= ST_LOAD;
                  end
               end
            end
            default: begin
               state     <= ST_LOAD;
               k         <= 2'd0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// tb/tb_cmp_sort4_ctrl.sv - bench for cmp_sort4_ctrl, ascending and descending instances in lockstep

module tb_cmp_sort4_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       out_ready = 1'b1;

   logic       in_ready_a, out_valid_a, out_last_a, busy_a;
   logic [3:0] out_data_a;
   logic [2:0] swaps_a;
   logic       in_ready_d, out_valid_d, out_last_d, busy_d;
   logic [3:0] out_data_d;
   logic [2:0] swaps_d;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cmp_sort4_ctrl #(.DESCEND(1'b0)) u_dut_asc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
      .out_last(out_last_a), .swaps(swaps_a), .busy(busy_a)
   );

   cmp_sort4_ctrl #(.DESCEND(1'b1)) u_dut_desc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
      .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready),
      .out_last(out_last_d), .swaps(swaps_d), .busy(busy_d)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: stable sort plus inversion count (bubble sort swaps exactly the inverted pairs)
   function automatic void ref_sort(input logic [3:0] w [4], input bit d,
                                    output logic [3:0] o [4], output int sw);
      logic [3:0] key;
      int j;
      sw = 0;
      for (int a = 0; a < 4; a++)
         for (int b = a + 1; b < 4; b++)
            if (d ? (w[a] < w[b]) : (w[a] > w[b])) sw++;
      o = w;
      for (int i = 1; i < 4; i++) begin
         key = o[i];
         j = i - 1;
         while (j >= 0 && (d ? (o[j] < key) : (o[j] > key))) begin
            o[j+1] = o[j];
            j--;
         end
         o[j+1] = key;
      end
   endfunction

   // Transaction-level model: 0 = collecting words, 1 = sorting (six cycles), 2 = handing out words
   int         m_mode = 0;
   int         m_cnt = 0;
   int         m_didx = 0;
   logic [3:0] m_ld [$];
   logic [3:0] exp_a [4];
   logic [3:0] exp_d [4];
   int         sw_a = 0;
   int         sw_d = 0;

   always @(posedge clk) begin
      logic [3:0] w [4];
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_didx = 0; sw_a = 0; sw_d = 0;
         m_ld.delete();
      end else begin
         case (m_mode)
            0: if (in_valid) begin
               m_ld.push_back(in_data);
               if (m_ld.size() == 4) begin
                  for (int i = 0; i < 4; i++) w[i] = m_ld[i];
                  ref_sort(w, 1'b0, exp_a, sw_a);
                  ref_sort(w, 1'b1, exp_d, sw_d);
                  m_ld.delete();
                  m_mode = 1; m_cnt = 0;
               end
            end
            1: begin
               m_cnt++;
               if (m_cnt == 6) begin m_mode = 2; m_didx = 0; end
            end
            default: if (out_ready) begin
               m_didx++;
               if (m_didx == 4) begin m_mode = 0; m_didx = 0; end
            end
         endcase
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready", in_ready_a, 1);   chk("rst_out_valid", out_valid_a, 0);
         chk("rst_busy", busy_a, 0);           chk("rst_out_last", out_last_a, 0);
         chk("rst_swaps", swaps_a, 0);         chk("rst_out_data", out_data_a, 0);
         chk("rst_in_ready_d", in_ready_d, 1); chk("rst_busy_d", busy_d, 0);
      end else begin
         chk("in_ready", in_ready_a, m_mode == 0);
         chk("out_valid", out_valid_a, m_mode == 2);
         chk("busy", busy_a, m_mode != 0);
         chk("out_last", out_last_a, (m_mode == 2) && (m_didx == 3));
         chk("in_ready_d", in_ready_d, m_mode == 0);
         chk("out_valid_d", out_valid_d, m_mode == 2);
         chk("out_last_d", out_last_d, (m_mode == 2) && (m_didx == 3));
         if (m_mode == 2) begin
            chk("out_data", out_data_a, exp_a[m_didx]);
            chk("out_data_d", out_data_d, exp_d[m_didx]);
         end
         if (m_mode != 1) begin
            chk("swaps", swaps_a, sw_a);
            chk("swaps_d", swaps_d, sw_d);
         end
      end
   end

   task automatic load4(input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input logic [3:0] w3);
      logic [3:0] w [4];
      int n;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      n = 0;
      while (!in_ready_a && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 40) chk("wait_in_ready_timeout", 0, 1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_batch(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2, input logic [3:0] w3,
                            input int stall_idx, input int stall_len, input bit poke,
                            output int lat, output int busy_n,
                            output logic [15:0] ga, output logic [15:0] gd);
      int got;
      int stalled;
      logic [3:0] held;
      load4(w0, w1, w2, w3);
      lat = 0; busy_n = 0; got = 0; stalled = 0; held = 4'd0;
      ga = 16'd0; gd = 16'd0;
      for (int c = 0; c < 60 && got < 4; c++) begin
         if (out_valid_a && got == stall_idx && stalled < stall_len) begin
            out_ready = 1'b0;
            if (stalled == 0) held = out_data_a;
            else chk("stall_hold_data", out_data_a, held);
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         if (poke) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            chk("poke_in_ready", in_ready_a, 0);
         end
         @(negedge clk);
         if (busy_a) busy_n++;
         if (out_valid_a && lat == 0) lat = c + 1;
         if (out_valid_a && out_ready) begin
            ga = {ga[11:0], out_data_a};
            gd = {gd[11:0], out_data_d};
            got++;
         end
         @(posedge clk); #1;
      end
      if (got < 4) chk("drain_timeout", got, 4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   int          lat, busy_n;
   logic [15:0] ga, gd;

   initial begin
      #12;
      @(posedge clk); #1;
      rst = 1'b0;

      run_batch(4'd3, 4'd1, 4'd2, 4'd0, 9, 0, 1'b0, lat, busy_n, ga, gd);
      chk("b1_out_asc", ga, 16'h0123);
      chk("b1_out_desc", gd, 16'h3210);
      chk("b1_latency", lat, 7);
      chk("b1_swaps", swaps_a, 5);
      chk("b1_swaps_d", swaps_d, 1);
      chk("b1_model_swaps", sw_a, 5);

      run_batch(4'd1, 4'd2, 4'd3, 4'd4, 9, 0, 1'b0, lat, busy_n, ga, gd);
      chk("b2_out_asc", ga, 16'h1234);
      chk("b2_out_desc", gd, 16'h4321);
      chk("b2_busy_cycles", busy_n, 10);
      chk("b2_swaps", swaps_a, 0);
      chk("b2_swaps_d", swaps_d, 6);

      run_batch(4'd5, 4'd5, 4'd2, 4'd5, 1, 3, 1'b1, lat, busy_n, ga, gd);
      chk("b3_out_asc", ga, 16'h2555);
      chk("b3_out_desc", gd, 16'h5552);
      chk("b3_busy_cycles", busy_n, 13);
      chk("b3_swaps", swaps_a, 2);
      chk("b3_swaps_d", swaps_d, 1);

      run_batch(4'd15, 4'd12, 4'd8, 4'd0, 9, 0, 1'b0, lat, busy_n, ga, gd);
      chk("b4_out_asc", ga, 16'h08CF);
      chk("b4_swaps", swaps_a, 6);
      chk("b4_swaps_d", swaps_d, 0);

      run_batch(4'd0, 4'd8, 4'd12, 4'd15, 9, 0, 1'b0, lat, busy_n, ga, gd);
      chk("b5_out_desc", gd, 16'hFC80);
      chk("b5_swaps_d", swaps_d, 6);
      chk("b5_swaps", swaps_a, 0);

      load4(4'd3, 4'd1, 4'd2, 4'd0);
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_busy", busy_a, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_in_ready", in_ready_a, 1);
      chk("async_rst_out_valid", out_valid_a, 0);
      chk("async_rst_busy", busy_a, 0);
      chk("async_rst_swaps", swaps_a, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_batch(4'd9, 4'd7, 4'd7, 4'd1, 9, 0, 1'b0, lat, busy_n, ga, gd);
      chk("b6_out_asc", ga, 16'h1779);
      chk("b6_out_desc", gd, 16'h9771);
      chk("b6_swaps", swaps_a, 5);
      chk("b6_swaps_d", swaps_d, 0);

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
